// File: rtl/pipeline_controller.sv
// pipeline_controller: hazard unit for a five-stage in-order pipeline.
//   - E-stage operand forwarding from M and W (only when FORWARDING_EN is defined)
//   - load-use stall, and an extended RAW stall when forwarding is absent
//   - data-memory wait handling with a timeout that latches a sticky error
//   - branch/jump flush and a saturating stalled-cycle counter
// Build option: define FORWARDING_EN to enable the M/W forwarding network.
//   When it is not defined, ForwardAE/ForwardBE are tied to 00. The load-use
//   stall then also covers any E or M producer, because nothing forwards them.
module pipeline_controller #(
  parameter int MEM_TIMEOUT = 15,  // max consecutive MEM_WAIT cycles without ack
  parameter int CNT_W       = 16   // width of the stalled-cycle counter
) (
  input  logic             CLK,
  input  logic             RST_N,
  // register indices per stage
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  // write enables per stage; ResultSrcE marks a load sitting in E
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  // control flow and data-memory handshake
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  // pipeline register hold / bubble controls
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  // E-stage operand selects: 00 register file, 01 W result, 10 M ALU result
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  // status
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCount
);

  // Controller states
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // The wait timer only has to hold values up to MEM_TIMEOUT
  localparam int             TMR_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(MEM_TIMEOUT);

  logic [1:0]       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [TMR_W-1:0] timer_inc;
  logic             err_reg, err_next;
  logic             branch_pending_reg, branch_pending_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             in_error;
  logic             mem_stall;
  logic             branch_flush;
  logic             raw_hazard;
  logic             load_use_stall;
  logic             stall_front;   // StallF/StallD before the reset override
  logic             stall_back;    // StallE/StallM/FlushW before the reset override
  logic             flush_e_int;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             unused_fwd_in;

  // ---------------------------------------------------------------------------
  // Hazard detection. Register x0 never causes a hazard. W-stage producers are
  // not checked: the register file writes first and reads second in a cycle.
  // ---------------------------------------------------------------------------
  logic load_hit;
  assign load_hit = ResultSrcE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef FORWARDING_EN
  // Only a load in E is a hazard; every other producer reaches E by forwarding.
  always_comb begin
    raw_hazard = load_hit;
  end

  // Select operand sources. M has priority over W because it holds the younger value.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      fwd_a = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      fwd_a = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      fwd_b = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      fwd_b = 2'b01;
  end

  // The load hazard is detected through ResultSrcE, so RegWriteE is not read here.
  assign unused_fwd_in = RegWriteE;
`else
  // Without forwarding, any producer still in E or M must drain first.
  always_comb begin
    raw_hazard = load_hit;
    if (RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)))
      raw_hazard = 1'b1;
    if (RegWriteM && (RdM != 5'd0) && ((RdM == Rs1D) || (RdM == Rs2D)))
      raw_hazard = 1'b1;
  end

  // The operand selects always read the register file.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end

  // The E-stage sources and the W producer only feed the forwarding network.
  assign unused_fwd_in = ^{Rs1E, Rs2E, RdW, RegWriteW};
`endif

  // ---------------------------------------------------------------------------
  // Stall / flush resolution. Priority: ERROR > mem stall > branch > load-use.
  // ---------------------------------------------------------------------------
  assign in_error  = (state_reg == ST_ERROR);
  assign mem_stall = !in_error && MemReqM && !MemAckM;

  // A branch seen during a memory stall is remembered. It flushes in the first
  // cycle after the stall releases, even if PCSrcE has dropped by then.
  assign branch_flush   = !in_error && !mem_stall && (PCSrcE || branch_pending_reg);
  assign load_use_stall = !in_error && !mem_stall && !branch_flush && raw_hazard;

  assign stall_back  = in_error || mem_stall;
  assign stall_front = stall_back || load_use_stall;
  assign flush_e_int = branch_flush || load_use_stall;

  // Drive outputs. While reset is held, the front end is flushed and nothing stalls.
  always_comb begin
    if (!RST_N) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else begin
      StallF    = stall_front;
      StallD    = stall_front;
      StallE    = stall_back;
      StallM    = stall_back;
      FlushD    = branch_flush;
      FlushE    = flush_e_int;
      FlushW    = stall_back;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  assign MemTimeoutErr = err_reg;
  assign StallCount    = count_reg;

  // ---------------------------------------------------------------------------
  // Memory-wait FSM. The timer counts MEM_WAIT cycles that have no ack. A
  // request withdrawn without an ack also returns to RUN. ERROR is left only
  // through reset.
  // ---------------------------------------------------------------------------
  assign timer_inc = timer_reg + 1'b1;

  // Compute the next state, timer and error flag
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_RUN: begin
        timer_next = '0;
        if (mem_stall)
          state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_next = ST_RUN;
          timer_next = '0;
        end else if (timer_inc == TIMEOUT_VAL) begin
          state_next = ST_ERROR;
          timer_next = timer_inc;
          err_next   = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
        err_next   = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
        timer_next = '0;
      end
    endcase
  end

  // Hold a branch for as long as a memory stall hides it, and drop it once it has flushed
  always_comb begin
    branch_pending_next = 1'b0;
    if (mem_stall)
      branch_pending_next = branch_pending_reg || PCSrcE;
  end

  // Count cycles in which fetch is held, saturating at all ones
  always_comb begin
    count_next = count_reg;
    if (stall_front && !(&count_reg))
      count_next = count_reg + 1'b1;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg          <= ST_RUN;
      timer_reg          <= '0;
      err_reg            <= 1'b0;
      branch_pending_reg <= 1'b0;
      count_reg          <= '0;
    end else begin
      state_reg          <= state_next;
      timer_reg          <= timer_next;
      err_reg            <= err_next;
      branch_pending_reg <= branch_pending_next;
      count_reg          <= count_next;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed checks of pipeline_controller.
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit after that. The counter is made narrow so that saturation is reachable.
module tb_pipeline_controller;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_LOAD   = 7'b1100010;
  localparam logic [6:0] C_MEM    = 7'b1111001;
  localparam logic [6:0] C_BRANCH = 7'b0000110;
  localparam logic [6:0] C_RESET  = 7'b0000110;

  logic             CLK, RST_N;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteE, RegWriteM, RegWriteW, ResultSrcE;
  logic             PCSrcE, MemReqM, MemAckM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemTimeoutErr;
  logic [CNT_W-1:0] StallCount;
  logic [6:0]       ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  pipeline_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeoutErr(MemTimeoutErr), .StallCount(StallCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
    PCSrcE = 0; MemReqM = 0; MemAckM = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle_inputs();
    ResultSrcE = 1; RdE = 3; Rs1D = 3; MemReqM = 1; PCSrcE = 1;
    tick();
    checks++;
    if (ctl !== C_RESET) begin
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET); errors++;
    end
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      $display("FAIL reset_fwd: got %b expected 0000", {ForwardAE, ForwardBE}); errors++;
    end
    checks++;
    if ({MemTimeoutErr, StallCount} !== 5'b0) begin
      $display("FAIL reset_status: got err=%b cnt=%0d expected err=0 cnt=0", MemTimeoutErr, StallCount); errors++;
    end
    idle_inputs();
    RST_N = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      $display("FAIL reset_release: got %b expected %b", ctl, C_IDLE); errors++;
    end
    $display("reset: ctl=%b cnt=%0d err=%b", ctl, StallCount, MemTimeoutErr);
  endtask

  task automatic test_forwarding();
    idle_inputs();
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
    #1;
    checks++;
    if (ForwardAE !== (FWD ? 2'b10 : 2'b00)) begin
      $display("FAIL fwd_m_over_w: got %b expected %b", ForwardAE, FWD ? 2'b10 : 2'b00); errors++;
    end
    RegWriteM = 0;
    #1;
    checks++;
    if (ForwardAE !== (FWD ? 2'b01 : 2'b00)) begin
      $display("FAIL fwd_w_only: got %b expected %b", ForwardAE, FWD ? 2'b01 : 2'b00); errors++;
    end
    idle_inputs();
    RegWriteM = 1; RdM = 9; Rs2E = 9; Rs1E = 4;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== (FWD ? 4'b0010 : 4'b0000)) begin
      $display("FAIL fwd_b_m: got %b expected %b", {ForwardAE, ForwardBE}, FWD ? 4'b0010 : 4'b0000); errors++;
    end
    idle_inputs();
    RegWriteM = 1; RegWriteW = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      $display("FAIL fwd_x0: got %b expected 0000", {ForwardAE, ForwardBE}); errors++;
    end
    $display("forwarding: fa=%b fb=%b", ForwardAE, ForwardBE);
    idle_inputs();
  endtask

  task automatic test_load_use();
    test_reset();
    ResultSrcE = 1; RegWriteE = 1; RdE = 3; Rs2D = 3;
    #1;
    checks++;
    if (ctl !== C_LOAD) begin
      $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LOAD); errors++;
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({ctl, StallCount} !== {C_IDLE, 4'd1}) begin
      $display("FAIL load_use_after: got ctl=%b cnt=%0d expected ctl=%b cnt=1", ctl, StallCount, C_IDLE); errors++;
    end
    ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      $display("FAIL load_use_x0: got %b expected %b", ctl, C_IDLE); errors++;
    end
    idle_inputs();
    RegWriteM = 1; RdM = 7; Rs1D = 7;
    #1;
    checks++;
    if (ctl !== (FWD ? C_IDLE : C_LOAD)) begin
      $display("FAIL raw_m_producer: got %b expected %b", ctl, FWD ? C_IDLE : C_LOAD); errors++;
    end
    idle_inputs();
    RegWriteE = 1; RdE = 6; Rs2D = 6;
    #1;
    checks++;
    if (ctl !== (FWD ? C_IDLE : C_LOAD)) begin
      $display("FAIL raw_e_producer: got %b expected %b", ctl, FWD ? C_IDLE : C_LOAD); errors++;
    end
    $display("load_use: ctl=%b cnt=%0d", ctl, StallCount);
    idle_inputs();
  endtask

  task automatic test_branch();
    test_reset();
    ResultSrcE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      $display("FAIL branch_over_load: got %b expected %b", ctl, C_BRANCH); errors++;
    end
    MemReqM = 1;
    #1;
    checks++;
    if (ctl !== C_MEM) begin
      $display("FAIL mem_over_branch: got %b expected %b", ctl, C_MEM); errors++;
    end
    tick();
    tick();
    MemAckM = 1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      $display("FAIL held_branch_release: got %b expected %b", ctl, C_BRANCH); errors++;
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({ctl, StallCount} !== {C_IDLE, 4'd2}) begin
      $display("FAIL held_branch_after: got ctl=%b cnt=%0d expected ctl=%b cnt=2", ctl, StallCount, C_IDLE); errors++;
    end
    MemReqM = 1; PCSrcE = 1;
    tick();
    RST_N = 1'b0;
    idle_inputs();
    tick();
    RST_N = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      $display("FAIL reset_drops_branch: got %b expected %b", ctl, C_IDLE); errors++;
    end
    $display("branch: ctl=%b cnt=%0d", ctl, StallCount);
  endtask

  task automatic test_mem_wait();
    test_reset();
    MemReqM = 1; MemAckM = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== C_MEM) begin
        $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, ctl, C_MEM); errors++;
      end
      tick();
    end
    MemAckM = 1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      $display("FAIL mem_ack: got %b expected %b", ctl, C_IDLE); errors++;
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({MemTimeoutErr, StallCount} !== {1'b0, 4'd4}) begin
      $display("FAIL mem_wait_status: got err=%b cnt=%0d expected err=0 cnt=4", MemTimeoutErr, StallCount); errors++;
    end
    // 15 stalled cycles: one in RUN plus 14 in MEM_WAIT, just under the timeout
    MemReqM = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if ({MemTimeoutErr, ctl} !== {1'b0, C_MEM}) begin
      $display("FAIL mem_wait_no_timeout: got err=%b ctl=%b expected err=0 ctl=%b", MemTimeoutErr, ctl, C_MEM); errors++;
    end
    MemAckM = 1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({MemTimeoutErr, StallCount} !== {1'b0, 4'd15}) begin
      $display("FAIL count_saturate: got err=%b cnt=%0d expected err=0 cnt=15", MemTimeoutErr, StallCount); errors++;
    end
    $display("mem_wait: err=%b cnt=%0d", MemTimeoutErr, StallCount);
  endtask

  task automatic test_timeout();
    test_reset();
    MemReqM = 1; MemAckM = 0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (MemTimeoutErr !== 1'b0) begin
      $display("FAIL timeout_early: got %b expected 0", MemTimeoutErr); errors++;
    end
    tick();
    checks++;
    if ({MemTimeoutErr, ctl} !== {1'b1, C_MEM}) begin
      $display("FAIL timeout_set: got err=%b ctl=%b expected err=1 ctl=%b", MemTimeoutErr, ctl, C_MEM); errors++;
    end
    for (int i = 0; i < 4; i++) tick();
    MemReqM = 0; MemAckM = 1; PCSrcE = 1;
    #1;
    checks++;
    if (ctl !== C_MEM) begin
      $display("FAIL error_holds: got %b expected %b", ctl, C_MEM); errors++;
    end
    tick();
    checks++;
    if ({MemTimeoutErr, StallCount} !== {1'b1, 4'd15}) begin
      $display("FAIL error_sticky: got err=%b cnt=%0d expected err=1 cnt=15", MemTimeoutErr, StallCount); errors++;
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({MemTimeoutErr, StallCount, ctl} !== {1'b0, 4'd0, C_RESET}) begin
      $display("FAIL error_reset: got err=%b cnt=%0d ctl=%b expected err=0 cnt=0 ctl=%b", MemTimeoutErr, StallCount, ctl, C_RESET); errors++;
    end
    tick();
    RST_N = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if ({MemTimeoutErr, StallCount, ctl} !== {1'b0, 4'd0, C_IDLE}) begin
      $display("FAIL error_cleared: got err=%b cnt=%0d ctl=%b expected err=0 cnt=0 ctl=%b", MemTimeoutErr, StallCount, ctl, C_IDLE); errors++;
    end
    $display("timeout: err=%b cnt=%0d ctl=%b", MemTimeoutErr, StallCount, ctl);
  endtask

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall-cycle counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  input  5 each  source/destination register indices per stage.
REQ-006 SHALL have ports RegWriteE, RegWriteM, RegWriteW, ResultSrcE  input  1 each  write enables per stage; ResultSrcE=1 marks load in E.
REQ-007 SHALL have ports PCSrcE  input  1  taken branch/jump in E; MemReqM, MemAckM  input  1 each  data-memory request/acknowledge in M.
REQ-008 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW  output  1 each  pipeline register hold/bubble controls.
REQ-009 SHALL have ports ForwardAE, ForwardBE  output  2 each  E-stage operand select: 00 register file, 01 W result, 10 M ALU result.
REQ-010 SHALL have ports MemTimeoutErr  output  1  sticky error; StallCount  output  CNT_W  saturating count of stalled cycles.

Function
REQ-011 SHALL implement states RUN, MEM_WAIT, ERROR; register index 0 SHALL never produce a hazard or forward.
REQ-012 SHALL drive ForwardAE=10 if RegWriteM and RdM==Rs1E, else 01 if RegWriteW and RdW==Rs1E, else 00; ForwardBE identically with Rs2E.
REQ-013 SHALL assert load-use stall (StallF, StallD, FlushE) combinationally when ResultSrcE and RdE equals Rs1D or Rs2D.
REQ-014 SHALL assert mem stall (StallF, StallD, StallE, StallM, FlushW) combinationally whenever MemReqM=1 and MemAckM=0 in RUN or MEM_WAIT.
REQ-015 SHALL transition RUN->MEM_WAIT at the edge when mem stall active; MEM_WAIT->RUN at the edge when MemAckM=1, clearing the wait timer.
REQ-016 SHALL increment the wait timer each MEM_WAIT cycle without MemAckM; on reaching MEM_TIMEOUT, SHALL transition to ERROR and set MemTimeoutErr.
REQ-017 SHALL, in ERROR, hold StallF, StallD, StallE, StallM, FlushW at 1 and remain until reset.
REQ-018 SHALL, when PCSrcE=1 and no mem stall, assert FlushD and FlushE and suppress load-use stall (StallF=StallD=0).
REQ-019 SHALL ignore PCSrcE while mem stall active; held branch SHALL flush in first cycle after stall releases.
REQ-020 SHALL apply priority ERROR > mem stall > branch flush > load-use stall.
REQ-021 SHALL increment StallCount every cycle StallF=1, saturating at all ones.
REQ-022 SHALL NOT check W-stage producers for stalls; register file resolves same-cycle write/read.

Reset
REQ-023 SHALL, while RST_N=0, force state RUN, wait timer 0, StallCount 0, MemTimeoutErr 0.
REQ-024 SHALL, while RST_N=0, drive FlushD=FlushE=1, all Stall*, FlushW=0, ForwardAE=ForwardBE=00.
REQ-025 SHALL, on reset during MEM_WAIT or ERROR, return to RUN with no pending branch flush.

Configuration
REQ-026 SHALL, with FORWARDING_EN defined, implement REQ-012 forwarding.
REQ-027 SHALL, without FORWARDING_EN, tie ForwardAE=ForwardBE=00 and extend load-use stall to any RegWriteE or RegWriteM producer whose Rd matches Rs1D/Rs2D.

Verification
REQ-028 SHALL cover: RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 -> ForwardAE=10 (priority M over W).
REQ-029 SHALL cover: ResultSrcE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 one cycle; StallCount=1 after.
REQ-030 SHALL cover: ResultSrcE=1, RdE=3, Rs1D=3, PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-031 SHALL cover: MemReqM=1, MemAckM=0 for 4 cycles then 1 -> four stall cycles, MEM_WAIT exit, StallCount=4, MemTimeoutErr=0.
REQ-032 SHALL cover: MemReqM=1, MemAckM held 0 for 20 cycles, MEM_TIMEOUT=15 -> MemTimeoutErr=1 after 15 wait cycles, stalls held; RST_N pulse clears all.
